parity_frame_tx: RTL
====================

Name: parity_frame_tx

Overview:
- Serial frame transmitter for the even-count line check.
- Accepts a parallel DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per enabled cycle.
- Appends a 2-bit trailer so every transmitted frame holds an even number of 0s and an even number of 1s.
- Feeds the serial input of the even-0s/even-1s detector FSM. At end of frame the detector must report even_0s=1 and even_1s=1.

Parameters:
- DATA_W, 8, payload width. Must be even and ≥2; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  word to transmit
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- tx_en  input  1  shift enable; low stalls the line
- tx_bit  output  1  serial line bit
- tx_valid  output  1  tx_bit is a frame bit
- tx_sof  output  1  tx_bit is the first frame bit
- tx_eof  output  1  tx_bit is the last frame bit
- done  output  1  one-cycle pulse: frame completed

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0:
  - state=IDLE; shift register, bit counter and parity cleared.
  - in_ready=1; tx_bit=0, tx_valid=0, tx_sof=0, tx_eof=0, done=0.
- Reset mid-frame aborts the frame immediately. No trailer is sent and done is not pulsed. After release the block is in IDLE with in_ready=1.
- States: IDLE, DATA, TRAIL0, TRAIL1.
- IDLE:
  - in_ready=1, tx_valid=0, tx_bit=0.
  - On the edge where in_valid=1:
    - load shift register with in_data;
    - parity = XOR-reduce(in_data);
    - bit counter = DATA_W-1;
    - go to DATA.
  - tx_en is ignored in IDLE.
- DATA:
  - tx_bit = shift register MSB, tx_valid=1, in_ready=0.
  - tx_sof=1 only while the first payload bit (counter=DATA_W-1) is presented.
  - On an edge with tx_en=1: shift left by 1 and decrement the counter. If the counter was 0, go to TRAIL0.
  - tx_en=0: hold all state; the bit stays on the line.
- TRAIL0:
  - tx_bit = parity, tx_valid=1.
  - On an edge with tx_en=1, go to TRAIL1.
- TRAIL1:
  - tx_bit=0, tx_valid=1, tx_eof=1.
  - On an edge with tx_en=1, go to IDLE and assert done for exactly the following cycle.
- Trailer rule: DATA_W is even, so payload 0s-parity equals payload 1s-parity.
  - parity=0 → trailer 0,0 (two 0s, both counts stay even).
  - parity=1 → trailer 1,0 (one 1 and one 0, fixes both counts).
  - Frame length is DATA_W+2 bits.
- Latency:
  - Word accepted at edge k → first payload bit on tx_bit in cycle k+1.
  - With tx_en held high, done is high in cycle k+DATA_W+3.
- Back-to-back frames:
  - in_ready returns high in the cycle done pulses.
  - A word presented then is accepted on that edge, giving a 1-cycle idle gap (tx_valid=0) between frames.
- in_valid while busy is ignored. The word is not captured; the producer must hold it until in_ready=1.
- Words captured at acceptance. in_data changes after acceptance do not affect the frame in flight.
- tx_sof and tx_eof are never high together.
- done is never high while tx_valid=1.
- All outputs derive from registered state; there is no combinational path from in_data to tx_bit.

Test Plan:
- 0xA5, tx_en=1 → tx_bit 1,0,1,0,0,1,0,1,0,0. tx_sof on the 1st bit, tx_eof on the 10th, done the next cycle. A connected detector shows even_0s=1, even_1s=1 after the 10th bit.
- 0x07 → payload 0,0,0,0,0,1,1,1 then trailer 1,0. The frame has 4 ones and 6 zeros, both even.
- 0x80 with tx_en toggled 1,0,0,1,… → every bit held exactly for its stall cycles. Frame content equals the unstalled case; done arrives once, after the final enabled TRAIL1 edge.
- Two words 0xFF then 0x01 with in_valid held high → second accepted in the done cycle. Frames are 1,1,1,1,1,1,1,1,0,0 and 0,0,0,0,0,0,0,1,1,0, with one tx_valid=0 cycle between them.
- in_valid pulsed with 0x3C during DATA of frame 0x55 → ignored. Frame 0x55 completes unchanged with trailer 0,0.
- reset_n low at the 4th payload bit → outputs go to reset values immediately without a clock, no done pulse. After release, in_ready=1 and a new word 0x01 transmits a correct full frame.

Source files
------------

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: shifts a DATA_W-bit word out MSB-first and appends
// a 2-bit trailer (parity, 0) so each frame carries an even number of 0s and an
// even number of 1s. Feeds the even-0s/even-1s line detector.
module parity_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              tx_en,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic              done
);

  // The trailer trick only works when the payload length is even: then the
  // parity of the 0s equals the parity of the 1s and one fix-up bit pair
  // corrects both counts at once.
  generate
    if ((DATA_W < 2) || ((DATA_W % 2) != 0)) begin : g_bad_width
      $error("parity_frame_tx: DATA_W must be even and >= 2");
    end
  endgenerate

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    TRAIL0 = 2'd2,
    TRAIL1 = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               par_q,   par_d;
  logic               done_q,  done_d;

  // State register: reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: capture the word on acceptance, then advance only on tx_en.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          par_d   = ^in_data;
          cnt_d   = CNT_FIRST;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tx_en) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = TRAIL0;
          end
        end
      end
      TRAIL0: begin
        if (tx_en) begin
          state_d = TRAIL1;
        end
      end
      TRAIL1: begin
        if (tx_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so in_data never reaches tx_bit
  // combinationally.
  always_comb begin
    in_ready = 1'b0;
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    done     = done_q;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      DATA: begin
        tx_bit   = shreg_q[DATA_W-1];
        tx_valid = 1'b1;
        tx_sof   = (cnt_q == CNT_FIRST);
      end
      TRAIL0: begin
        tx_bit   = par_q;
        tx_valid = 1'b1;
      end
      TRAIL1: begin
        tx_bit   = 1'b0;
        tx_valid = 1'b1;
        tx_eof   = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
